// File: rtl/clk_rst_sequencer_if.sv
// Reset-sequencer handshake and per-domain reset bundle.
interface clk_rst_sequencer_if #(
  parameter int unsigned FANOUT = 4
);
  logic              sw_rst_req;
  logic              sw_rst_ack;
  logic [FANOUT-1:0] reset_n;
  logic              rst_done;
  logic              busy;

  modport master (
    input  sw_rst_req,
    output sw_rst_ack,
    output reset_n,
    output rst_done,
    output busy
  );

  modport slave (
    output sw_rst_req,
    input  sw_rst_ack,
    input  reset_n,
    input  rst_done,
    input  busy
  );
endinterface

// File: rtl/clk_rst_sequencer.sv
// Holds all domain resets low, then releases them one at a time (index 0 first)
// with a fixed gap; re-runs the sequence on a software request.
module clk_rst_sequencer #(
  parameter int unsigned FANOUT      = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  clk_rst_sequencer_if.master     bus
);

  localparam int unsigned MAX_DLY = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;

  if (FANOUT < 1 || FANOUT > 32) begin : g_bad_fanout
    $error("clk_rst_sequencer: FANOUT must be 1..32");
  end
  if (HOLD_CYCLES < 1 || STAGE_GAP < 1) begin : g_bad_delay
    $error("clk_rst_sequencer: HOLD_CYCLES and STAGE_GAP must be >= 1");
  end
  if ((64'd1 << CNT_W) <= 64'(MAX_DLY)) begin : g_bad_cnt_w
    $error("clk_rst_sequencer: CNT_W too narrow for HOLD_CYCLES/STAGE_GAP");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_DONE
  } state_e;

  state_e            state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [FANOUT-1:0] reset_n_q,  reset_n_d;
  logic              rst_done_q, rst_done_d;
  logic              busy_q,     busy_d;
  logic              ack_q,      ack_d;
  logic              pending_q,  pending_d;
  logic              release_step;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    reset_n_d    = reset_n_q;
    pending_d    = pending_q;
    ack_d        = 1'b0;
    release_step = 1'b0;

    unique case (state_q)
      ST_ASSERT: begin
        if (cnt_q == HOLD_LAST) release_step = 1'b1;
        else                    cnt_d = cnt_q + CNT_W'(1);
      end
      ST_RELEASE: begin
        if (cnt_q == GAP_LAST) release_step = 1'b1;
        else                   cnt_d = cnt_q + CNT_W'(1);
      end
      ST_DONE: begin
        if (bus.sw_rst_req && !ack_q) begin
          state_d   = ST_ASSERT;
          reset_n_d = '0;
          cnt_d     = '0;
          pending_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_ASSERT;
        reset_n_d = '0;
        cnt_d     = '0;
      end
    endcase

    // Released bits form a thermometer code, so each release shifts in one more 1.
    if (release_step) begin
      reset_n_d = (reset_n_q << 1) | FANOUT'(1);
      cnt_d     = '0;
      if (&reset_n_d) begin
        state_d   = ST_DONE;
        ack_d     = pending_q;
        pending_d = 1'b0;
      end else begin
        state_d   = ST_RELEASE;
      end
    end

    rst_done_d = (state_d == ST_DONE);
    busy_d     = !rst_done_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ASSERT;
      cnt_q      <= '0;
      reset_n_q  <= '0;
      rst_done_q <= 1'b0;
      busy_q     <= 1'b1;
      ack_q      <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reset_n_q  <= reset_n_d;
      rst_done_q <= rst_done_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      pending_q  <= pending_d;
    end
  end

  assign bus.reset_n    = reset_n_q;
  assign bus.rst_done   = rst_done_q;
  assign bus.busy       = busy_q;
  assign bus.sw_rst_ack = ack_q;

endmodule
